// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for the shared data memory
//
// Grants the CPU memory stage or the debug/loader port one access at a time,
// holds the data_mem strobes for WAIT_CYCLES cycles, then returns a one-cycle
// ready pulse to the winner with the shared read-data register.
//
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie-breaking;
// when undefined the CPU always wins simultaneous requests.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (held until cpu_ready)
//   cpu_ready, cpu_rdata         CPU completion pulse and read data
//   dbg_req/we/addr/wdata        debug/loader request (held until dbg_ready)
//   dbg_ready, dbg_rdata         debug completion pulse and read data
//   mem_MemRead, mem_MemWrite    strobes to data_mem (ACCESS state only)
//   mem_address, mem_write_data  latched address / write data to data_mem
//   mem_read_data                read data from data_mem
//   busy                         high whenever the sequencer is not IDLE
//   grant_dbg                    current or most recent grant went to debug

`ifndef WORD
`define WORD 64
`endif

module dmem_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [`WORD-1:0] cpu_addr,
   input  logic [`WORD-1:0] cpu_wdata,
   output logic             cpu_ready,
   output logic [`WORD-1:0] cpu_rdata,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [`WORD-1:0] dbg_addr,
   input  logic [`WORD-1:0] dbg_wdata,
   output logic             dbg_ready,
   output logic [`WORD-1:0] dbg_rdata,
   output logic             mem_MemRead,
   output logic             mem_MemWrite,
   output logic [`WORD-1:0] mem_address,
   output logic [`WORD-1:0] mem_write_data,
   input  logic [`WORD-1:0] mem_read_data,
   output logic             busy,
   output logic             grant_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic             lat_we;
   logic [`WORD-1:0] lat_addr;
   logic [`WORD-1:0] lat_wdata;
   logic [`WORD-1:0] rdata;
   logic             any_req;
   logic             pick_dbg;

   // Winner selection, only consulted in IDLE.
   always_comb begin
      any_req = cpu_req | dbg_req;
`ifdef DMEM_ARB_RR_EN
      // On a tie the port that did not win last time goes; grant_dbg is that history.
      pick_dbg = dbg_req & (~cpu_req | ~grant_dbg);
`else
      pick_dbg = dbg_req & ~cpu_req;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Strobes, ready and busy decode straight from the state register, so an
   // asynchronous reset drops them without waiting for a clock edge.
   always_comb begin
      state_nxt    = state;
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      cpu_ready    = 1'b0;
      dbg_ready    = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_MemRead  = ~lat_we;
            mem_MemWrite = lat_we;
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            cpu_ready = ~grant_dbg;
            dbg_ready = grant_dbg;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata     <= '0;
         grant_dbg <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_dbg <= pick_dbg;
                  lat_we    <= pick_dbg ? dbg_we    : cpu_we;
                  lat_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
                  lat_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                  cnt       <= CNT_LOAD;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!lat_we) begin
                  rdata <= mem_read_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_address    = lat_addr;
   assign mem_write_data = lat_wdata;
   assign cpu_rdata      = rdata;
   assign dbg_rdata      = rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural model

module tb_dmem_arbiter;

   localparam int WC = 3;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   typedef struct packed {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [63:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_ready, dbg_ready, mem_MemRead, mem_MemWrite, busy, grant_dbg;
   logic [63:0] cpu_rdata, dbg_rdata, mem_address, mem_write_data, mem_read_data;

   int tests = 0;
   int fails = 0;

   txn_t cpu_q[$];
   txn_t dbg_q[$];
   int   grant_q[$];

   bit          mon_en = 1'b0;
   int          cyc = 0;
   int          acc_start = 0;
   int          strobe_n = 0;
   bit          strobe_bad = 1'b0;
   bit          prev_busy = 1'b0, prev_cpu = 1'b0, prev_dbg = 1'b0;
   bit          prev_cr = 1'b0, prev_dr = 1'b0;
   int          last_win = 1;
   logic        seen_we;
   logic [63:0] seen_addr, seen_wd;
   logic [63:0] last_rd = 64'h0;

   always #5 clk = ~clk;

   // Memory stand-in: data is a fixed function of the address, and only
   // meaningful while the read strobe is up.
   function automatic logic [63:0] mem_fn(input logic [63:0] a);
      return {a[31:0] ^ 32'hC3A5_5A3C, a[63:32] + a[31:0] + 32'h1357_9BDF};
   endfunction

   assign mem_read_data = mem_MemRead ? mem_fn(mem_address) : 64'hBAD0_BAD0_BAD0_BAD0;

   dmem_arbiter #(.WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data),
      .busy(busy), .grant_dbg(grant_dbg)
   );

   task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard: watches grants, strobes and ready pulses.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en && !reset) begin
            if (busy && !prev_busy) begin
               int w;
               if (!prev_cpu && !prev_dbg) check("spurious_grant", 1'b0, 1, 0);
               if (prev_cpu && prev_dbg) w = RR_EN ? (last_win == 1 ? 0 : 1) : 0;
               else w = prev_dbg ? 1 : 0;
               check("grant_dbg", grant_dbg == w[0], grant_dbg, w);
               grant_q.push_back(w);
               last_win   = w;
               acc_start  = cyc;
               strobe_n   = 0;
               strobe_bad = 1'b0;
            end
            if (mem_MemRead || mem_MemWrite) begin
               if (strobe_n == 0) begin
                  seen_we   = mem_MemWrite;
                  seen_addr = mem_address;
                  seen_wd   = mem_write_data;
               end else if (seen_we != mem_MemWrite || seen_addr != mem_address ||
                            seen_wd != mem_write_data) begin
                  strobe_bad = 1'b1;
               end
               if (mem_MemRead && mem_MemWrite) strobe_bad = 1'b1;
               strobe_n++;
            end
            if ((cpu_ready && prev_cr) || (dbg_ready && prev_dr))
               check("ready_pulse_width", 1'b0, 1, 0);
            if (cpu_ready && dbg_ready) check("both_ready", 1'b0, 1, 0);
            if (cpu_ready || dbg_ready) begin
               int   p;
               int   w;
               txn_t t;
               logic [63:0] exp_rd, rd;
               p = dbg_ready ? 1 : 0;
               if (grant_q.size() == 0 || (p == 1 ? dbg_q.size() : cpu_q.size()) == 0) begin
                  check("unexpected_ready", 1'b0, p, 0);
               end else begin
                  w = grant_q.pop_front();
                  check("ready_port", p == w, p, w);
                  t = (p == 1) ? dbg_q.pop_front() : cpu_q.pop_front();
                  check("latency", (cyc - acc_start) == WC, cyc - acc_start, WC);
                  check("strobe_cycles", strobe_n == WC && !strobe_bad, strobe_n, WC);
                  check("strobe_we", seen_we == t.we, seen_we, t.we);
                  check("mem_address", seen_addr == t.addr, seen_addr, t.addr);
                  if (t.we) check("mem_write_data", seen_wd == t.wdata, seen_wd, t.wdata);
                  exp_rd = t.we ? last_rd : mem_fn(t.addr);
                  rd     = (p == 1) ? dbg_rdata : cpu_rdata;
                  check("rdata", rd == exp_rd, rd, exp_rd);
                  check("rdata_shared", cpu_rdata == dbg_rdata, dbg_rdata, cpu_rdata);
                  check("strobes_off_in_resp", !mem_MemRead && !mem_MemWrite,
                        {mem_MemRead, mem_MemWrite}, 0);
                  if (!t.we) last_rd = exp_rd;
               end
            end
         end
         prev_busy = busy;
         prev_cpu  = cpu_req;
         prev_dbg  = dbg_req;
         prev_cr   = cpu_ready;
         prev_dr   = dbg_ready;
      end
   end

   // One access on port p; call at posedge+#1. Returns at posedge+#1 of the
   // IDLE cycle following ready, with req still high if hold is set.
   task automatic issue(input bit p, input bit we, input logic [63:0] a, input logic [63:0] d,
                        input bit hold, input bit drop);
      txn_t t;
      int   k;
      t.we = we; t.addr = a; t.wdata = d;
      if (p) begin
         dbg_q.push_back(t);
         dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
      end else begin
         cpu_q.push_back(t);
         cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      end
      if (drop) begin
         repeat (2) @(posedge clk);
         #1;
         if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
      k = 0;
      while (k < 300) begin
         @(negedge clk);
         if (p ? dbg_ready : cpu_ready) break;
         k++;
      end
      if (k >= 300) check("ready_timeout", 1'b0, 0, 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
   endtask

   task automatic rand_port(input bit p, input int n);
      bit          hold;
      logic [63:0] a;
      for (int i = 0; i < n; i++) begin
         hold = (i < n - 1) && ($urandom_range(0, 1) == 1);
         a    = 64'($urandom_range(0, 255)) << 3;
         issue(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, hold, 1'b0);
         if (!hold) repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy == 1'b0, busy, 0);
      check("rst_grant_dbg", grant_dbg == 1'b1, grant_dbg, 1);
      check("rst_strobes", !mem_MemRead && !mem_MemWrite, {mem_MemRead, mem_MemWrite}, 0);
      check("rst_ready", !cpu_ready && !dbg_ready, {cpu_ready, dbg_ready}, 0);
      check("rst_rdata", cpu_rdata == 64'h0, cpu_rdata, 0);
      check("rst_addr", mem_address == 64'h0, mem_address, 0);
      check("rst_wdata", mem_write_data == 64'h0, mem_write_data, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Directed: CPU read, debug write, simultaneous held requests,
      // request dropped mid-access, back-to-back CPU reads.
      issue(1'b0, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      issue(1'b1, 1'b1, 64'h20, 64'h1234, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      fork
         begin
            for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 64'h100 + 64'(i * 8), 64'h0, i < 3, 1'b0);
         end
         begin
            for (int j = 0; j < 4; j++) issue(1'b1, 1'b1, 64'h200 + 64'(j * 8), 64'hA000 + 64'(j), j < 3, 1'b0);
         end
      join
      repeat (2) begin @(posedge clk); #1; end
      issue(1'b0, 1'b0, 64'h48, 64'h0, 1'b0, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
      issue(1'b0, 1'b0, 64'h50, 64'h0, 1'b1, 1'b0);
      issue(1'b0, 1'b0, 64'h58, 64'h0, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end

      fork
         rand_port(1'b0, 30);
         rand_port(1'b1, 30);
      join
      repeat (3) begin @(posedge clk); #1; end
      check("cpu_q_drained", cpu_q.size() == 0, cpu_q.size(), 0);
      check("dbg_q_drained", dbg_q.size() == 0, dbg_q.size(), 0);
      check("grant_q_drained", grant_q.size() == 0, grant_q.size(), 0);

      // Reset in the middle of a write access.
      mon_en = 1'b0;
      cpu_we = 1'b1; cpu_addr = 64'h40; cpu_wdata = 64'h5555; cpu_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_reset_strobe", mem_MemWrite == 1'b1 && busy == 1'b1, {mem_MemWrite, busy}, 2'b11);
      reset = 1'b1;
      #1;
      check("mid_rst_strobes", !mem_MemRead && !mem_MemWrite, {mem_MemRead, mem_MemWrite}, 0);
      check("mid_rst_busy", busy == 1'b0, busy, 0);
      check("mid_rst_grant_dbg", grant_dbg == 1'b1, grant_dbg, 1);
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_quiet", !cpu_ready && !dbg_ready && !busy, {cpu_ready, dbg_ready, busy}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
